// File: rtl/tetris_playfield.sv
`default_nettype none
// ============================================================================
// Module      : tetris_playfield
// Description : Occupancy grid for a falling-block game. It locks 4-cell
//               pieces, removes full rows and tracks line count / game over.
// Revision    : 1.0 - initial release
// ============================================================================
module tetris_playfield #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         restart,
    input  logic                         lock_valid,
    output logic                         lock_ready,
    input  logic [4*$clog2(COLS)-1:0]    lock_x,
    input  logic [4*$clog2(ROWS)-1:0]    lock_y,
    input  logic [4*$clog2(COLS)-1:0]    q_x,
    input  logic [4*$clog2(ROWS)-1:0]    q_y,
    output logic                         q_hit,
    output logic [ROWS*COLS-1:0]         grid_state,
    output logic                         busy,
    output logic                         clear_done,
    output logic [2:0]                   lines_cleared,
    output logic [15:0]                  total_lines,
    output logic                         game_over
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;
    logic [ROWS-1:0][COLS-1:0]  r_grid;
    logic [RW-1:0]              r_scan_row;
    logic [2:0]                 r_count;
    logic [2:0]                 r_lines;
    logic [15:0]                r_total;
    logic                       r_game_over;

    logic [ROWS-1:0][COLS-1:0]  w_lock_mask;
    logic                       w_lock_hit;
    logic                       w_q_hit;
    logic                       w_lock_fire;
    logic                       w_row_full;
    logic [16:0]                w_total_sum;

    // One-hot grid position of a cell; all zero when the cell is off the field.
    function automatic logic [ROWS-1:0][COLS-1:0] cell_onehot(
        input logic [CW-1:0] x,
        input logic [RW-1:0] y
    );
        cell_onehot = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (y == RW'(r) && x == CW'(c)) begin
                    cell_onehot[r][c] = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic cell_hit(
        input logic [CW-1:0]               x,
        input logic [RW-1:0]               y,
        input logic [ROWS-1:0][COLS-1:0]   grid
    );
        logic [ROWS-1:0][COLS-1:0] oh;
        oh       = cell_onehot(x, y);
        cell_hit = (oh == '0) || ((oh & grid) != '0);
    endfunction

    always_comb begin
        w_lock_mask = '0;
        w_lock_hit  = 1'b0;
        w_q_hit     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_lock_mask = w_lock_mask | cell_onehot(lock_x[i*CW +: CW], lock_y[i*RW +: RW]);
            if (cell_hit(lock_x[i*CW +: CW], lock_y[i*RW +: RW], r_grid)) begin
                w_lock_hit = 1'b1;
            end
            if (cell_hit(q_x[i*CW +: CW], q_y[i*RW +: RW], r_grid)) begin
                w_q_hit = 1'b1;
            end
        end
    end

    assign lock_ready  = (r_state == IDLE) && !r_game_over;
    assign busy        = (r_state == SCAN) || (r_state == DONE);
    assign clear_done  = (r_state == DONE);
    assign w_lock_fire = lock_valid && lock_ready;
    assign w_row_full  = &r_grid[r_scan_row];
    assign w_total_sum = {1'b0, r_total} + {14'd0, r_count};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_lock_fire) begin
                    w_next_state = w_lock_hit ? OVER : SCAN;
                end
            end
            SCAN: begin
                if (!w_row_full && r_scan_row == '0) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = (|r_grid[0]) ? OVER : IDLE;
            default: w_next_state = r_state;
        endcase
        if (restart) begin
            w_next_state = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grid      <= '0;
            r_scan_row  <= '0;
            r_count     <= '0;
            r_lines     <= '0;
            r_total     <= '0;
            r_game_over <= 1'b0;
        end else if (restart) begin
            r_grid      <= '0;
            r_scan_row  <= '0;
            r_count     <= '0;
            r_lines     <= '0;
            r_total     <= '0;
            r_game_over <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_lock_fire) begin
                        if (w_lock_hit) begin
                            r_game_over <= 1'b1;
                        end else begin
                            r_grid     <= r_grid | w_lock_mask;
                            r_scan_row <= RW'(ROWS - 1);
                            r_count    <= '0;
                        end
                    end
                end
                SCAN: begin
                    if (w_row_full) begin
                        // Drop everything above the full row; the scan row is
                        // re-examined next step since it now holds new content.
                        for (int r = ROWS - 1; r >= 1; r--) begin
                            if (RW'(r) <= r_scan_row) begin
                                r_grid[r] <= r_grid[r-1];
                            end
                        end
                        r_grid[0] <= '0;
                        r_count   <= r_count + 3'd1;
                    end else if (r_scan_row != '0) begin
                        r_scan_row <= r_scan_row - 1'b1;
                    end else begin
                        r_lines <= r_count;
                        r_total <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
                    end
                end
                DONE: begin
                    if (|r_grid[0]) begin
                        r_game_over <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign q_hit         = w_q_hit;
    assign grid_state    = r_grid;
    assign lines_cleared = r_lines;
    assign total_lines   = r_total;
    assign game_over     = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_tetris_playfield.sv
`default_nettype none
// Directed bench for tetris_playfield (10x20): expected sequence results are
// queued at lock time and compared whenever clear_done pulses.
module tb_tetris_playfield;

    logic         clk = 1'b0;
    logic         reset, restart, lock_valid;
    logic [15:0]  lock_x, q_x;
    logic [19:0]  lock_y, q_y;
    logic         lock_ready, q_hit, busy, clear_done, game_over;
    logic [199:0] grid_state;
    logic [2:0]   lines_cleared;
    logic [15:0]  total_lines;

    always #5 clk = ~clk;

    tetris_playfield #(.COLS(10), .ROWS(20)) dut (
        .clk(clk), .reset(reset), .restart(restart),
        .lock_valid(lock_valid), .lock_ready(lock_ready),
        .lock_x(lock_x), .lock_y(lock_y), .q_x(q_x), .q_y(q_y),
        .q_hit(q_hit), .grid_state(grid_state), .busy(busy),
        .clear_done(clear_done), .lines_cleared(lines_cleared),
        .total_lines(total_lines), .game_over(game_over)
    );

    typedef struct {
        logic [2:0]   lines;
        logic [15:0]  total;
        logic [199:0] grid;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [199:0] row_bits(input int r, input int c0, input int c1);
        logic [199:0] v;
        v = '0;
        for (int c = c0; c <= c1; c++) v[r*10+c] = 1'b1;
        return v;
    endfunction

    function automatic logic [199:0] col_bits(input int c, input int r0, input int r1);
        logic [199:0] v;
        v = '0;
        for (int r = r0; r <= r1; r++) v[r*10+c] = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] px(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic logic [19:0] py(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (clear_done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_clear_done: got pulse at cycle %0d, required none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("lines_cleared", 200'(lines_cleared), 200'(mon_e.lines));
                chk("total_lines", 200'(total_lines), 200'(mon_e.total));
                chk("grid_after_seq", grid_state, mon_e.grid);
                chk("clear_done_cycle", 200'(cyc), 200'(mon_e.cyc));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle_timeout: got busy=1 after 60 cycles, required 0");
        end
    endtask

    task automatic do_lock(input logic [15:0] lx, input logic [19:0] ly, input logic [2:0] k,
                           input logic [15:0] tot, input logic [199:0] g, input bit exp_over);
        exp_t e;
        @(negedge clk);
        chk("lock_ready_before", 200'(lock_ready), 200'(1));
        lock_x = lx; lock_y = ly; lock_valid = 1'b1;
        e.lines = k; e.total = tot; e.grid = g;
        e.cyc = cyc + 1 + 20 + int'(k);
        sb.push_back(e);
        @(posedge clk);
        #1 lock_valid = 1'b0;
        wait_idle();
        chk("game_over_after_seq", 200'(game_over), 200'(exp_over));
        chk("lock_ready_after_seq", 200'(lock_ready), 200'(!exp_over));
    endtask

    task automatic try_ignored(input logic [199:0] g);
        @(negedge clk);
        lock_x = px(1, 2, 3, 4); lock_y = py(10, 10, 10, 10); lock_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("ignored_lock_grid", grid_state, g);
        chk("ignored_lock_ready", 200'(lock_ready), 200'(0));
        chk("ignored_lock_busy", 200'(busy), 200'(0));
        lock_valid = 1'b0;
    endtask

    task automatic do_bad_lock(input logic [15:0] lx, input logic [19:0] ly, input logic [199:0] g);
        @(negedge clk);
        lock_x = lx; lock_y = ly; lock_valid = 1'b1;
        @(posedge clk);
        #1 lock_valid = 1'b0;
        @(negedge clk);
        chk("collide_game_over", 200'(game_over), 200'(1));
        chk("collide_grid", grid_state, g);
        chk("collide_busy", 200'(busy), 200'(0));
        try_ignored(g);
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart_grid", grid_state, '0);
        chk("restart_game_over", 200'(game_over), 200'(0));
        chk("restart_total", 200'(total_lines), 200'(0));
        chk("restart_lines", 200'(lines_cleared), 200'(0));
        chk("restart_lock_ready", 200'(lock_ready), 200'(1));
    endtask

    task automatic build_two_rows(input logic [15:0] tot);
        do_lock(px(0, 1, 2, 3), py(19, 19, 19, 19), 0, tot, row_bits(19, 0, 3), 0);
        do_lock(px(4, 5, 6, 7), py(19, 19, 19, 19), 0, tot, row_bits(19, 0, 7), 0);
        do_lock(px(0, 1, 2, 3), py(18, 18, 18, 18), 0, tot, row_bits(19, 0, 7) | row_bits(18, 0, 3), 0);
        do_lock(px(4, 5, 6, 7), py(18, 18, 18, 18), 0, tot, row_bits(19, 0, 7) | row_bits(18, 0, 7), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [199:0] g;
        reset = 1'b1; restart = 1'b0; lock_valid = 1'b0;
        lock_x = '0; lock_y = '0; q_x = '0; q_y = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_grid", grid_state, '0);
        chk("reset_lock_ready", 200'(lock_ready), 200'(1));
        chk("reset_busy", 200'(busy), 200'(0));
        chk("reset_game_over", 200'(game_over), 200'(0));
        chk("reset_total", 200'(total_lines), 200'(0));
        chk("reset_clear_done", 200'(clear_done), 200'(0));

        // Bottom row filled in three pieces; the O piece completes it.
        do_lock(px(0, 1, 2, 3), py(19, 19, 19, 19), 0, 0, row_bits(19, 0, 3), 0);
        do_lock(px(4, 5, 6, 7), py(19, 19, 19, 19), 0, 0, row_bits(19, 0, 7), 0);
        do_lock(px(8, 9, 8, 9), py(18, 18, 19, 19), 1, 1, row_bits(19, 8, 9), 0);

        @(negedge clk);
        q_x = px(9, 0, 0, 0); q_y = py(19, 0, 0, 0);
        #1 chk("q_hit_occupied", 200'(q_hit), 200'(1));
        q_x = px(0, 1, 2, 3); q_y = py(19, 19, 19, 19);
        #1 chk("q_hit_free", 200'(q_hit), 200'(0));
        q_x = px(0, 1, 2, 3); q_y = py(19, 19, 19, 20);
        #1 chk("q_hit_y_range", 200'(q_hit), 200'(1));
        q_x = px(0, 1, 10, 3); q_y = py(5, 5, 5, 5);
        #1 chk("q_hit_x_range", 200'(q_hit), 200'(1));

        // Duplicate coordinates are a legal lock
        g = row_bits(19, 0, 0) | row_bits(19, 8, 9);
        do_lock(px(0, 0, 0, 0), py(19, 19, 19, 19), 0, 1, g, 0);

        do_bad_lock(px(10, 1, 1, 1), py(0, 1, 2, 3), g);
        do_restart();

        g = row_bits(18, 5, 6) | row_bits(19, 5, 6);
        do_lock(px(5, 6, 5, 6), py(18, 18, 19, 19), 0, 0, g, 0);
        do_bad_lock(px(5, 5, 5, 5), py(15, 16, 17, 19), g);
        do_restart();

        // Vertical I pieces stacked up to the top row
        for (int i = 0; i < 5; i++) begin
            do_lock(px(0, 0, 0, 0), py(16 - 4*i, 17 - 4*i, 18 - 4*i, 19 - 4*i),
                    0, 0, col_bits(0, 16 - 4*i, 19), (i == 4));
        end
        try_ignored(col_bits(0, 0, 19));
        do_restart();

        // Two rows removed by one lock
        build_two_rows(0);
        do_lock(px(8, 9, 8, 9), py(18, 18, 19, 19), 2, 2, '0, 0);

        // Same situation, reset lands in the middle of the scan
        build_two_rows(2);
        @(negedge clk);
        lock_x = px(8, 9, 8, 9); lock_y = py(18, 18, 19, 19); lock_valid = 1'b1;
        @(posedge clk);
        #1 lock_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midscan_reset_grid", grid_state, '0);
        chk("midscan_reset_busy", 200'(busy), 200'(0));
        chk("midscan_reset_clear_done", 200'(clear_done), 200'(0));
        chk("midscan_reset_total", 200'(total_lines), 200'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("post_reset_grid", grid_state, '0);
        chk("post_reset_lock_ready", 200'(lock_ready), 200'(1));

        do_lock(px(2, 3, 4, 5), py(19, 19, 19, 19), 0, 0, row_bits(19, 2, 5), 0);

        chk("scoreboard_drained", 200'(sb.size()), 200'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
